// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM encoding, bubble instruction, stall-vector bit positions.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Bit positions in the ctrl stall vector, shared with the ctrl block.
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction bus: req/gnt address phase, rvalid data phase, one fetch in flight.
interface if_fetch_unit_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;

  modport master (
    output ibus_req, ibus_addr,
    input  ibus_gnt, ibus_rvalid, ibus_rdata
  );

  modport slave (
    input  ibus_req, ibus_addr,
    output ibus_gnt, ibus_rvalid, ibus_rdata
  );
endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// 1-entry {inst,pc} holding register for a response that arrives while IF/ID is stalled.
// Clear beats load beats unload; contents visible the cycle after load.
module if_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       unload,
  input  fetch_ent_t in_ent,
  output logic       vld,
  output fetch_ent_t out_ent
);

  logic       vld_q, vld_d;
  fetch_ent_t ent_q, ent_d;

  always_comb begin
    vld_d = vld_q;
    ent_d = ent_q;
    if (clear) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = 1'b1;
      ent_d = in_ent;
    end else if (unload) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ent_q <= '0;
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
    end
  end

  assign vld     = vld_q;
  assign out_ent = ent_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one ibus fetch in flight, feeds the IF/ID registers.
// req->id_valid is 2 cycles; stall[1] freezes IF/ID and parks a late response in the skid buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_fetch_unit_pkg::NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_jump_flag,
  input  logic [31:0]           ctrl_jump_addr,
  input  logic [5:0]            stall,
  if_fetch_unit_if.master       ibus,
  output logic                  id_valid,
  output logic [31:0]           id_inst,
  output logic [31:0]           id_pc
);
  import if_fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cap_pc_q, cap_pc_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic [31:0]  id_pc_q, id_pc_d;

  logic       jump;
  logic       rsp;
  logic       buf_vld;
  logic       buf_load;
  logic       buf_unload;
  logic       buf_vld_nxt;
  fetch_ent_t buf_ent;
  fetch_ent_t rsp_ent;
  logic       unused_stall;

  assign jump         = ctrl_jump_flag;
  // Only a response to a live fetch counts; drained data never reaches the pipe.
  assign rsp          = (state_q == S_WAIT) && ibus.ibus_rvalid;
  assign rsp_ent      = '{inst: ibus.ibus_rdata, pc: cap_pc_q};
  assign buf_load     = rsp && stall[STALL_IF];
  assign buf_unload   = buf_vld && !stall[STALL_IF];
  assign buf_vld_nxt  = buf_load || (buf_vld && !buf_unload);
  assign unused_stall = ^stall[5:2];

  if_skid_buf u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (jump),
    .load    (buf_load),
    .unload  (buf_unload),
    .in_ent  (rsp_ent),
    .vld     (buf_vld),
    .out_ent (buf_ent)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cap_pc_d   = cap_pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;

    if (jump) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (!stall[STALL_IF]) begin
      if (buf_vld) begin
        id_valid_d = 1'b1;
        id_inst_d  = buf_ent.inst;
        id_pc_d    = buf_ent.pc;
      end else if (rsp) begin
        id_valid_d = 1'b1;
        id_inst_d  = rsp_ent.inst;
        id_pc_d    = rsp_ent.pc;
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = NOP_INST;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (jump || (!stall[STALL_PC] && !buf_vld)) state_d = S_REQ;
      end
      S_REQ: begin
        if (ibus.ibus_gnt) begin
          if (jump) begin
            state_d = S_DRAIN;
          end else begin
            pc_d     = pc_q + 32'd4;
            cap_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (jump) begin
          state_d = ibus.ibus_rvalid ? S_REQ : S_DRAIN;
        end else if (ibus.ibus_rvalid) begin
          state_d = (!stall[STALL_PC] && !buf_vld_nxt) ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        // The stale response must be swallowed even if another redirect lands meanwhile.
        if (ibus.ibus_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (jump) pc_d = ctrl_jump_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      cap_pc_q   <= 32'h0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cap_pc_q   <= cap_pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign ibus.ibus_req  = (state_q == S_REQ);
  assign ibus.ibus_addr = pc_q;
  assign id_valid       = id_valid_q;
  assign id_inst        = id_inst_q;
  assign id_pc          = id_pc_q;

endmodule
